rf_wb_arbiter: RTL

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//
// Purpose:
//   Two-requester writeback arbiter for a single register-file write port.
//   Requester A is the ALU writeback and requester B is the load writeback.
//   When both requesters are valid, the grant alternates between them using
//   a round-robin pointer. The winning write is registered onto the rf_*
//   outputs, so there is one cycle from grant to rf_write.
//
// Handshake:
//   A transfer on requester X completes in the cycle where X_valid and
//   X_ready are both 1. X_ready is combinational from the valids, stall and
//   last_grant. At most one ready is high in a cycle. A requester must hold
//   valid, wreg and wdata stable until it is accepted; this block does not
//   check that.
//
// Ports:
//   clk                 clock; all state updates on its rising edge
//   rst                 asynchronous, active-high reset
//   a_valid/a_wreg/a_wdata  requester A request (1 / 5 / 32 bits)
//   a_ready             requester A accepted this cycle
//   b_valid/b_wreg/b_wdata  requester B request (1 / 5 / 32 bits)
//   b_ready             requester B accepted this cycle
//   stall               blocks every grant while high
//   rf_write/rf_wreg/rf_wdata  registered register-file write port
//   last_grant          round-robin pointer (0 = A last, 1 = B last)
//
// Optional feature (macro RF_WB_BYPASS_EN):
//   q_sreg/q_treg (in, 5), rf_sdata/rf_tdata (in, 32), q_sdata/q_tdata
//   (out, 32). This adds a combinational read bypass that forwards the
//   in-flight write to the two read ports.
// ---------------------------------------------------------------------------
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_wreg,
  input  logic [31:0] a_wdata,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_wreg,
  input  logic [31:0] b_wdata,
  output logic        b_ready,
  input  logic        stall,
  output logic        rf_write,
  output logic [4:0]  rf_wreg,
  output logic [31:0] rf_wdata,
  output logic        last_grant
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [4:0]  q_sreg,
  input  logic [4:0]  q_treg,
  input  logic [31:0] rf_sdata,
  input  logic [31:0] rf_tdata,
  output logic [31:0] q_sdata,
  output logic [31:0] q_tdata
`endif
);

  // Registered state
  logic        r_rf_write;
  logic [4:0]  r_rf_wreg;
  logic [31:0] r_rf_wdata;
  logic        r_last_grant;

  // Grant decode
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_xfer;
  logic [4:0]  w_win_wreg;
  logic [31:0] w_win_wdata;
  logic        w_win_nonzero;

  // Grant logic. The reset term keeps both readies low while rst is high,
  // even though the pointer is already forced to 1 by then.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!rst && !stall) begin
      if (a_valid && b_valid) begin
        // Contention: the requester that did not win last time goes next.
        w_grant_a = r_last_grant;
        w_grant_b = ~r_last_grant;
      end else begin
        w_grant_a = a_valid;
        w_grant_b = b_valid;
      end
    end
  end

  assign w_xfer        = w_grant_a | w_grant_b;
  assign w_win_wreg    = w_grant_b ? b_wreg  : a_wreg;
  assign w_win_wdata   = w_grant_b ? b_wdata : a_wdata;
  // r0 is hardwired. A write to r0 is accepted but never reaches the file.
  assign w_win_nonzero = (w_win_wreg != 5'd0);

  // Write-port register and round-robin pointer. A write to r0 and an idle
  // cycle both leave rf_wreg/rf_wdata at their last real write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf_write   <= 1'b0;
      r_rf_wreg    <= 5'd0;
      r_rf_wdata   <= 32'd0;
      r_last_grant <= 1'b1;
    end else begin
      r_rf_write <= w_xfer & w_win_nonzero;
      if (w_xfer && w_win_nonzero) begin
        r_rf_wreg  <= w_win_wreg;
        r_rf_wdata <= w_win_wdata;
      end
      if (w_xfer) begin
        r_last_grant <= w_grant_b;
      end
    end
  end

  assign a_ready    = w_grant_a;
  assign b_ready    = w_grant_b;
  assign rf_write   = r_rf_write;
  assign rf_wreg    = r_rf_wreg;
  assign rf_wdata   = r_rf_wdata;
  assign last_grant = r_last_grant;

`ifdef RF_WB_BYPASS_EN
  // Forward the write that is landing this cycle, so a reader does not see
  // the stale file contents for one cycle.
  logic w_hit_s;
  logic w_hit_t;

  assign w_hit_s = r_rf_write && (r_rf_wreg == q_sreg);
  assign w_hit_t = r_rf_write && (r_rf_wreg == q_treg);
  assign q_sdata = w_hit_s ? r_rf_wdata : rf_sdata;
  assign q_tdata = w_hit_t ? r_rf_wdata : rf_tdata;
`endif

endmodule
